// File: rtl/stopwatch_disp_pkg.sv
// Shared definitions for the stopwatch display path: time-word field positions,
// FSM states, the 7-segment decode and the decimal-point digit positions.
package stopwatch_disp_pkg;

  localparam int TIME_W  = 27;
  localparam int H_MSB   = 26;
  localparam int H_LSB   = 22;
  localparam int M_MSB   = 21;
  localparam int M_LSB   = 16;
  localparam int S_MSB   = 15;
  localparam int S_LSB   = 10;
  localparam int MS_MSB  = 9;
  localparam int MS_LSB  = 0;

  localparam int FIELD_W = 10;
  localparam int BCD_W   = 12;

  localparam logic [9:0] MS_MAX = 10'd999;

  localparam logic [2:0] DP_IDX_HM = 3'd6;
  localparam logic [2:0] DP_IDX_MS = 3'd4;
  localparam logic [2:0] DP_IDX_SC = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV_MS,
    ST_CONV_S,
    ST_CONV_M,
    ST_CONV_H,
    ST_COMMIT
  } state_t;

  // Active-low gfedcba; anything that is not a decimal digit is dark.
  function automatic logic [6:0] seg_lut(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [9:0] sat_ms(input logic [9:0] ms);
    return (ms > MS_MAX) ? MS_MAX : ms;
  endfunction

  function automatic logic is_dp_digit(input logic [2:0] idx);
    return (idx == DP_IDX_HM) || (idx == DP_IDX_MS) || (idx == DP_IDX_SC);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter (shift-add-3).
// Loads on the start edge, shifts on the next 10 edges, then pulses done for one cycle.
module bin2bcd_seq
  import stopwatch_disp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [FIELD_W-1:0] i_bin,
  output logic               o_busy,
  output logic               o_done,
  output logic [BCD_W-1:0]   o_bcd
);

  localparam int SR_W = BCD_W + FIELD_W;

  logic [SR_W-1:0] r_sr;
  logic [3:0]      r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [SR_W-1:0] w_adj;

  // NOTE: w_adj takes its default before the per-digit overrides, so no latch can form.
  always_comb begin
    w_adj = r_sr;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r_sr[FIELD_W + 4*i +: 4] >= 4'd5)
        w_adj[FIELD_W + 4*i +: 4] = r_sr[FIELD_W + 4*i +: 4] + 4'd3;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_sr   <= {{BCD_W{1'b0}}, i_bin};
      r_cnt  <= 4'(FIELD_W);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_sr  <= {w_adj[SR_W-2:0], 1'b0};
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_sr[SR_W-1:FIELD_W];

endmodule

// File: rtl/stopwatch_display.sv
// Snapshots the stopwatch time word, converts ms/s/m/h to BCD through one shared
// converter, and scans HH.MM.SS.cc onto an 8-digit common-anode display.
module stopwatch_display
  import stopwatch_disp_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 100,
  parameter int SCAN_HZ    = 8000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TIME_W-1:0] disp_time,
  input  logic              blank,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [7:0]        an,
  output logic              bcd_valid
);

  localparam int UPD_DIV  = CLK_HZ / REFRESH_HZ;
  localparam int UPD_W    = $clog2(UPD_DIV);
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int SCAN_W   = $clog2(SCAN_DIV);

  logic [UPD_W-1:0]   r_upd_cnt;
  logic [SCAN_W-1:0]  r_scan_cnt;
  logic               w_upd_tick;
  logic               w_scan_tick;

  state_t             r_state;
  state_t             w_state_nx;
  logic               w_start;
  logic [FIELD_W-1:0] w_conv_in;
  logic               w_busy;
  logic               w_done;
  logic [BCD_W-1:0]   w_bcd;

  logic [4:0]         r_snap_h;
  logic [5:0]         r_snap_m;
  logic [5:0]         r_snap_s;
  logic [7:0]         r_ms_bcd;
  logic [7:0]         r_s_bcd;
  logic [7:0]         r_m_bcd;
  logic [7:0][3:0]    r_digits;
  logic               r_bcd_valid;

  logic [2:0]         r_idx;
  logic [3:0]         w_cur_digit;
  logic [6:0]         r_seg;
  logic               r_dp;
  logic [7:0]         r_an;

  assign w_upd_tick  = (r_upd_cnt == UPD_W'(UPD_DIV - 1));
  assign w_scan_tick = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_upd_cnt  <= '0;
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else begin
      r_upd_cnt  <= w_upd_tick  ? '0 : r_upd_cnt + 1'b1;
      r_scan_cnt <= w_scan_tick ? '0 : r_scan_cnt + 1'b1;
      if (w_scan_tick)
        r_idx <= r_idx + 3'd1;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_bin   (w_conv_in),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // The converter is restarted on the same edge that enters the next CONV state,
  // which keeps every field at exactly 11 cycles. The ms field is taken straight
  // from disp_time on the snapshot edge since it is the value being snapshotted.
  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_conv_in  = '0;
    case (r_state)
      ST_IDLE: if (w_upd_tick && !w_busy) begin
        w_start    = 1'b1;
        w_conv_in  = sat_ms(disp_time[MS_MSB:MS_LSB]);
        w_state_nx = ST_CONV_MS;
      end
      ST_CONV_MS: if (w_done) begin
        w_start    = 1'b1;
        w_conv_in  = {4'd0, r_snap_s};
        w_state_nx = ST_CONV_S;
      end
      ST_CONV_S: if (w_done) begin
        w_start    = 1'b1;
        w_conv_in  = {4'd0, r_snap_m};
        w_state_nx = ST_CONV_M;
      end
      ST_CONV_M: if (w_done) begin
        w_start    = 1'b1;
        w_conv_in  = {5'd0, r_snap_h};
        w_state_nx = ST_CONV_H;
      end
      ST_CONV_H: if (w_done) w_state_nx = ST_COMMIT;
      ST_COMMIT: w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
  end

  // NOTE: the digit register is reset because its contents are visible on the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap_h    <= '0;
      r_snap_m    <= '0;
      r_snap_s    <= '0;
      r_ms_bcd    <= '0;
      r_s_bcd     <= '0;
      r_m_bcd     <= '0;
      r_digits    <= '0;
      r_bcd_valid <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_upd_tick) begin
        r_snap_h <= disp_time[H_MSB:H_LSB];
        r_snap_m <= disp_time[M_MSB:M_LSB];
        r_snap_s <= disp_time[S_MSB:S_LSB];
      end
      if (w_done) begin
        case (r_state)
          ST_CONV_MS: r_ms_bcd <= w_bcd[11:4];
          ST_CONV_S:  r_s_bcd  <= w_bcd[7:0];
          ST_CONV_M:  r_m_bcd  <= w_bcd[7:0];
          default:    ;
        endcase
      end
      // The converter is idle in COMMIT and still holds the hours result.
      if (r_state == ST_COMMIT) begin
        r_digits    <= {w_bcd[7:0], r_m_bcd, r_s_bcd, r_ms_bcd};
        r_bcd_valid <= 1'b1;
      end
    end
  end

  assign w_cur_digit = r_digits[r_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (blank || !r_bcd_valid) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(8'd1 << r_idx);
      r_seg <= seg_lut(w_cur_digit);
      r_dp  <= ~is_dp_digit(r_idx);
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign an        = r_an;
  assign bcd_valid = r_bcd_valid;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with short dividers (refresh every 64 cycles,
// scan every 8). A second instance refreshing every 32 cycles exercises busy-time ticks.
module tb_stopwatch_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] disp_time;
  logic        blank;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        bcd_valid;

  logic        reset2;
  logic [26:0] disp_time2;
  logic        blank2 = 1'b0;
  logic [6:0]  seg2;
  logic        dp2;
  logic [7:0]  an2;
  logic        bcd_valid2;

  int n_checks = 0;
  int n_err    = 0;
  int e1 = 0;
  int e2 = 0;

  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [7:0] AN_TAB [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                                        8'hEF, 8'hDF, 8'hBF, 8'h7F};

  stopwatch_display #(.CLK_HZ(512), .REFRESH_HZ(8), .SCAN_HZ(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .disp_time (disp_time),
    .blank     (blank),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .bcd_valid (bcd_valid)
  );

  stopwatch_display #(.CLK_HZ(512), .REFRESH_HZ(16), .SCAN_HZ(64)) dut2 (
    .clk       (clk),
    .reset     (reset2),
    .disp_time (disp_time2),
    .blank     (blank2),
    .seg       (seg2),
    .dp        (dp2),
    .an        (an2),
    .bcd_valid (bcd_valid2)
  );

  always #5 clk = ~clk;

  // Edge counters since each instance's reset release.
  always @(posedge clk) begin
    e1 = reset  ? 0 : e1 + 1;
    e2 = reset2 ? 0 : e2 + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait1(input int k);
    while (e1 < k) @(negedge clk);
  endtask

  task automatic wait2(input int k);
    while (e2 < k) @(negedge clk);
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"},  an, 8'hFF);
    check({tag, "_seg"}, {1'b0, seg}, 8'h7F);
    check({tag, "_dp"},  {7'd0, dp}, 8'h01);
  endtask

  // Output at edge 8*j+4 shows scan index j mod 8; j0 is a multiple of 8.
  task automatic scan_check(input string tag, input int j0, input logic [7:0][3:0] d);
    for (int i = 0; i < 8; i++) begin
      wait1(8 * (j0 + i) + 4);
      check($sformatf("%s_an%0d", tag, i), an, AN_TAB[i]);
      check($sformatf("%s_seg%0d", tag, i), {1'b0, seg}, {1'b0, SEG_TAB[d[i]]});
      check($sformatf("%s_dp%0d", tag, i), {7'd0, dp},
            (i == 2 || i == 4 || i == 6) ? 8'h00 : 8'h01);
    end
  endtask

  initial begin
    reset      = 1'b1;
    reset2     = 1'b1;
    disp_time  = '0;
    blank      = 1'b0;
    disp_time2 = {5'd0, 6'd0, 6'd1, 10'd0};

    // Reset state, then first snapshot at edge 64 and commit at 64+45=109.
    repeat (3) @(negedge clk);
    check_off("reset");
    check("reset_valid", {7'd0, bcd_valid}, 8'h00);
    reset = 1'b0;
    wait1(108);
    check("pre_commit_valid", {7'd0, bcd_valid}, 8'h00);
    check("pre_commit_an", an, 8'hFF);
    wait1(109);
    check("commit_valid", {7'd0, bcd_valid}, 8'h01);
    check("commit_an_lag", an, 8'hFF);
    wait1(110);
    check("first_an", an, 8'hDF);
    check("first_seg", {1'b0, seg}, 8'h40);
    check("first_dp", {7'd0, dp}, 8'h01);
    scan_check("zero", 16, {8{4'd0}});

    // {12,34,56,789}: snapshot at 192, commit at 237.
    disp_time = {5'd12, 6'd34, 6'd56, 10'd789};
    scan_check("t1234", 32, {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8});

    // ms=1015 saturates to 999: snapshot at 320, commit at 365.
    disp_time = {5'd12, 6'd34, 6'd56, 10'd1015};
    scan_check("sat", 48, {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd9});

    // Blank across scan ticks at 448, 456, 464; index goes 7 -> 2.
    wait1(446);
    check("pre_blank_an", an, 8'h7F);
    check("pre_blank_seg", {1'b0, seg}, 8'h79);
    blank = 1'b1;
    wait1(449);
    check_off("blank_a");
    wait1(457);
    check_off("blank_b");
    wait1(465);
    check_off("blank_c");
    wait1(470);
    check("blank_d_an", an, 8'hFF);
    check("blank_valid", {7'd0, bcd_valid}, 8'h01);
    blank = 1'b0;
    wait1(471);
    check("unblank_an", an, 8'hFB);
    check("unblank_seg", {1'b0, seg}, 8'h02);
    check("unblank_dp", {7'd0, dp}, 8'h00);

    // Reset 20 cycles into the conversion that starts at edge 512.
    disp_time = {5'd12, 6'd34, 6'd56, 10'd789};
    wait1(531);
    check("pre_rst_an", an, 8'hFB);
    wait1(532);
    #1 reset = 1'b1;
    #1;
    check_off("midrst");
    check("midrst_valid", {7'd0, bcd_valid}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    wait1(108);
    check("rst2_pre_valid", {7'd0, bcd_valid}, 8'h00);
    wait1(109);
    check("rst2_valid", {7'd0, bcd_valid}, 8'h01);
    scan_check("rerun", 16, {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8});

    // Second instance: snapshot 32 (s=1), input changed at 42, tick at 64 while
    // busy is dropped, commit 77; next snapshot 96, commit 141; next commit 205.
    reset2 = 1'b0;
    wait2(42);
    disp_time2 = {5'd0, 6'd0, 6'd2, 10'd200};
    wait2(76);
    check("d2_pre_valid", {7'd0, bcd_valid2}, 8'h00);
    wait2(77);
    check("d2_valid", {7'd0, bcd_valid2}, 8'h01);
    wait2(84);
    check("d2_s01_an", an2, 8'hFB);
    check("d2_s01_seg", {1'b0, seg2}, 8'h79);
    check("d2_s01_dp", {7'd0, dp2}, 8'h00);
    wait2(140);
    check("d2_noqueue_an", an2, 8'hFD);
    check("d2_noqueue_seg", {1'b0, seg2}, 8'h40);
    wait2(148);
    check("d2_s02_an", an2, 8'hFB);
    check("d2_s02_seg", {1'b0, seg2}, 8'h24);
    wait2(204);
    check("d2_ms2_an", an2, 8'hFD);
    check("d2_ms2_seg", {1'b0, seg2}, 8'h24);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
